// File: rtl/change_payout_pkg.sv
// Shared types and constants for the change-payout block: FSM state encoding,
// coin values and the default amount width.
// Ports: none (package only).
package payout_pkg;

  localparam int AMT_W_DEF = 4;

  localparam logic [1:0] COIN_1 = 2'd1;
  localparam logic [1:0] COIN_2 = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_COIN = 3'd2,
    DONE      = 3'd3,
    FAULT     = 3'd4
  } state_t;

endpackage

// File: rtl/change_payout_if.sv
// Bundle of the change-request, hopper and status signals of change_payout.
// master: the side that drives requests and hopper feedback (seller FSM / hopper model).
// slave : the payout controller itself.
interface change_payout_if
  import payout_pkg::*;
#(
  parameter int AMT_W = AMT_W_DEF
);

  logic             change_req;
  logic [AMT_W-1:0] change_amount;
  logic             hopper_ready;
  logic             hopper2_empty;
  logic             coin_sensed;
  logic             fault_clr;
  logic             eject_2;
  logic             eject_1;
  logic             busy;
  logic             payout_done;
  logic             fault;
  logic [AMT_W-1:0] remaining_display;

  modport master (
    output change_req, change_amount, hopper_ready, hopper2_empty, coin_sensed, fault_clr,
    input  eject_2, eject_1, busy, payout_done, fault, remaining_display
  );

  modport slave (
    input  change_req, change_amount, hopper_ready, hopper2_empty, coin_sensed, fault_clr,
    output eject_2, eject_1, busy, payout_done, fault, remaining_display
  );

endinterface

// File: rtl/change_payout_watchdog.sv
// Coin-sensor watchdog: counts cycles spent waiting for a coin after an eject.
// Latency: expired is combinational from the count; it asserts once TIMEOUT-1 waiting cycles have elapsed.
// Backpressure: none; clr has priority over en, the count saturates at expiry.
// Ports: clk, reset (async active-low), clr (restart count), en (count this cycle), expired.
module payout_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // The FSM leaves WAIT_COIN on the edge where expired is seen, so the
  // fault lands exactly TIMEOUT edges after the eject edge that cleared us.
  assign expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/change_payout.sv
// Change-payout controller: pays a yuan amount through a 2-/1-yuan hopper, greedy 2s first, one coin in flight.
// Latency: request to first eject 1 cycle (if hopper_ready); next eject 1 cycle after each coin_sensed.
// Backpressure: ejects wait on hopper_ready; change_req outside IDLE is dropped, not queued.
// Ports: clk, reset (async active-low), pif (change_payout_if.slave: request, hopper, status).
// Optional: PAYOUT_TIMEOUT_EN adds the coin watchdog, FAULT state, fault and fault_clr.
module change_payout
  import payout_pkg::*;
#(
  parameter int AMT_W   = AMT_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  change_payout_if.slave pif
);

  state_t           state, state_nxt;
  logic [AMT_W-1:0] remaining, remaining_nxt;
  logic [1:0]       coin_val, coin_val_nxt;
  logic             eject_2_q, eject_1_q;
  logic             eject_2_nxt, eject_1_nxt;
  logic             wd_clr, wd_en, wd_expired;
  logic             fault_clr_eff;
  logic             take_2;

  // 2-coin only when it cannot underflow and the 2-yuan tube has stock;
  // hopper2_empty is looked at per coin so it may change mid-payout.
  assign take_2 = (remaining >= AMT_W'(COIN_2)) && !pif.hopper2_empty;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      coin_val  <= '0;
      eject_2_q <= 1'b0;
      eject_1_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      coin_val  <= coin_val_nxt;
      eject_2_q <= eject_2_nxt;
      eject_1_q <= eject_1_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pif.change_req) begin
          state_nxt = (pif.change_amount == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (pif.hopper_ready) state_nxt = WAIT_COIN;
      end
      WAIT_COIN: begin
        // A sensed coin wins over a same-edge watchdog expiry.
        if (pif.coin_sensed) begin
          state_nxt = (remaining == AMT_W'(coin_val)) ? DONE : ISSUE;
        end else if (wd_expired) begin
          state_nxt = FAULT;
        end
      end
      DONE:    state_nxt = IDLE;
      FAULT: begin
        if (fault_clr_eff) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- output / datapath logic ----------------
  always_comb begin
    remaining_nxt = remaining;
    coin_val_nxt  = coin_val;
    eject_2_nxt   = 1'b0;
    eject_1_nxt   = 1'b0;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;
    case (state)
      IDLE: begin
        if (pif.change_req) remaining_nxt = pif.change_amount;
      end
      ISSUE: begin
        if (pif.hopper_ready) begin
          wd_clr = 1'b1;
          if (take_2) begin
            eject_2_nxt  = 1'b1;
            coin_val_nxt = COIN_2;
          end else begin
            eject_1_nxt  = 1'b1;
            coin_val_nxt = COIN_1;
          end
        end
      end
      WAIT_COIN: begin
        if (pif.coin_sensed) begin
          remaining_nxt = remaining - AMT_W'(coin_val);
        end else begin
          wd_en = 1'b1;
        end
      end
      FAULT: begin
        if (fault_clr_eff) remaining_nxt = '0;
      end
      default: ;
    endcase
  end

  assign pif.eject_2           = eject_2_q;
  assign pif.eject_1           = eject_1_q;
  assign pif.busy              = (state != IDLE);
  assign pif.payout_done       = (state == DONE);
  assign pif.remaining_display = remaining;

`ifdef PAYOUT_TIMEOUT_EN
  payout_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign fault_clr_eff = pif.fault_clr;
  assign pif.fault     = (state == FAULT);
`else
  // No watchdog: WAIT_COIN waits forever, FAULT is unreachable.
  localparam int unused_timeout = TIMEOUT;
  logic unused_wd;

  assign wd_expired    = 1'b0;
  assign fault_clr_eff = 1'b0;
  assign pif.fault     = 1'b0;
  assign unused_wd     = wd_clr | wd_en | pif.fault_clr;
`endif

endmodule

// File: tb/tb_change_payout.sv
module tb_change_payout;

  logic clk;
  logic reset;

  int total;
  int bad;
  int both_hi;
  int done_cnt;

  int exp_ej[$];
  int exp_rem[$];
  int got_ej[$];
  int got_rem[$];

  change_payout_if #(.AMT_W(4)) pif ();

  change_payout #(
    .AMT_W   (4),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden greedy model: pushes the coin sequence and remaining-after-each-coin.
  task automatic push_expected(input int amt, input bit h2e);
    int r;
    r = amt;
    while (r > 0) begin
      if (r >= 2 && !h2e) begin
        exp_ej.push_back(2);
        r -= 2;
      end else begin
        exp_ej.push_back(1);
        r -= 1;
      end
      exp_rem.push_back(r);
    end
  endtask

  // One-cycle request; returns #1 after the sampling edge.
  task automatic send_req(input int amt);
    pif.change_req    = 1'b1;
    pif.change_amount = 4'(amt);
    @(posedge clk); #1;
    pif.change_req    = 1'b0;
  endtask

  // Hopper model: records ejects, senses each coin 2 cycles after its eject,
  // records remaining after each sensed coin, stops when busy drops.
  task automatic serve(input int budget, output int timed_out);
    int cnt_dn;
    cnt_dn    = 0;
    timed_out = 1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      pif.change_req = 1'b0;
      if (pif.coin_sensed) begin
        pif.coin_sensed = 1'b0;
        got_rem.push_back(int'(pif.remaining_display));
      end
      if (pif.eject_2 && pif.eject_1) begin
        both_hi++;
      end else if (pif.eject_2) begin
        got_ej.push_back(2);
        cnt_dn = 2;
      end else if (pif.eject_1) begin
        got_ej.push_back(1);
        cnt_dn = 2;
      end
      if (pif.payout_done) done_cnt++;
      if (!pif.busy) begin
        timed_out = 0;
        break;
      end
      if (cnt_dn > 0) begin
        cnt_dn--;
        if (cnt_dn == 0) pif.coin_sensed = 1'b1;
      end
    end
  endtask

  task automatic clear_queues();
    exp_ej.delete(); exp_rem.delete(); got_ej.delete(); got_rem.delete();
    both_hi  = 0;
    done_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pif.change_req = 1'b0; pif.change_amount = '0; pif.hopper_ready = 1'b1;
    pif.hopper2_empty = 1'b0; pif.coin_sensed = 1'b0; pif.fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", pif.busy); end
    total++; if (pif.eject_2 !== 1'b0 || pif.eject_1 !== 1'b0) begin bad++; $display("FAIL reset_eject got=%b%b exp=00", pif.eject_2, pif.eject_1); end
    total++; if (pif.payout_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", pif.payout_done); end
    total++; if (pif.fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", pif.fault); end
    total++; if (pif.remaining_display !== 4'd0) begin bad++; $display("FAIL reset_rem got=%0d exp=0", pif.remaining_display); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", pif.busy); end
  endtask

  task automatic test_amount5();
    int to, e, g;
    clear_queues();
    pif.hopper2_empty = 1'b0;
    push_expected(5, 1'b0);
    send_req(5);
    total++; if (pif.busy !== 1'b1) begin bad++; $display("FAIL a5_busy_start got=%b exp=1", pif.busy); end
    total++; if (pif.remaining_display !== 4'd5) begin bad++; $display("FAIL a5_rem_start got=%0d exp=5", pif.remaining_display); end
    serve(200, to);
    total++; if (to != 0) begin bad++; $display("FAIL a5_timeout got=%0d exp=0", to); end
    while (exp_ej.size() > 0) begin
      e = exp_ej.pop_front(); g = (got_ej.size() > 0) ? got_ej.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL a5_eject got=%0d exp=%0d", g, e); end
    end
    while (exp_rem.size() > 0) begin
      e = exp_rem.pop_front(); g = (got_rem.size() > 0) ? got_rem.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL a5_rem got=%0d exp=%0d", g, e); end
    end
    total++; if (got_ej.size() != 0) begin bad++; $display("FAIL a5_extra_eject got=%0d exp=0", got_ej.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL a5_done_pulses got=%0d exp=1", done_cnt); end
    total++; if (both_hi != 0) begin bad++; $display("FAIL a5_both_eject got=%0d exp=0", both_hi); end
  endtask

  task automatic test_zero();
    send_req(0);
    total++; if (pif.payout_done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", pif.payout_done); end
    total++; if (pif.busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%b exp=1", pif.busy); end
    total++; if (pif.eject_2 !== 1'b0 || pif.eject_1 !== 1'b0) begin bad++; $display("FAIL zero_eject got=%b%b exp=00", pif.eject_2, pif.eject_1); end
    @(posedge clk); #1;
    total++; if (pif.busy !== 1'b0 || pif.payout_done !== 1'b0) begin bad++; $display("FAIL zero_after got=%b%b exp=00", pif.busy, pif.payout_done); end
    total++; if (pif.eject_2 !== 1'b0 || pif.eject_1 !== 1'b0) begin bad++; $display("FAIL zero_eject2 got=%b%b exp=00", pif.eject_2, pif.eject_1); end
  endtask

  task automatic test_no_2coin();
    int to, e, g;
    clear_queues();
    pif.hopper2_empty = 1'b1;
    push_expected(3, 1'b1);
    send_req(3);
    serve(200, to);
    total++; if (to != 0) begin bad++; $display("FAIL no2_timeout got=%0d exp=0", to); end
    while (exp_ej.size() > 0) begin
      e = exp_ej.pop_front(); g = (got_ej.size() > 0) ? got_ej.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL no2_eject got=%0d exp=%0d", g, e); end
    end
    while (exp_rem.size() > 0) begin
      e = exp_rem.pop_front(); g = (got_rem.size() > 0) ? got_rem.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL no2_rem got=%0d exp=%0d", g, e); end
    end
    total++; if (got_ej.size() != 0) begin bad++; $display("FAIL no2_extra_eject got=%0d exp=0", got_ej.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL no2_done_pulses got=%0d exp=1", done_cnt); end
    pif.hopper2_empty = 1'b0;
  endtask

  task automatic test_ignore_req();
    int to, e, g;
    clear_queues();
    push_expected(4, 1'b0);
    send_req(4);
    // Second request lands while in ISSUE; serve drops it after one edge.
    pif.change_req    = 1'b1;
    pif.change_amount = 4'd9;
    serve(200, to);
    total++; if (to != 0) begin bad++; $display("FAIL ign_timeout got=%0d exp=0", to); end
    while (exp_ej.size() > 0) begin
      e = exp_ej.pop_front(); g = (got_ej.size() > 0) ? got_ej.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL ign_eject got=%0d exp=%0d", g, e); end
    end
    while (exp_rem.size() > 0) begin
      e = exp_rem.pop_front(); g = (got_rem.size() > 0) ? got_rem.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL ign_rem got=%0d exp=%0d", g, e); end
    end
    total++; if (got_ej.size() != 0) begin bad++; $display("FAIL ign_extra_eject got=%0d exp=0", got_ej.size()); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL ign_idle got=%b exp=0", pif.busy); end
  endtask

  task automatic test_hopper_wait();
    int to, seen;
    clear_queues();
    pif.hopper_ready = 1'b0;
    send_req(2);
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (pif.eject_2 || pif.eject_1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL hw_eject_while_busy got=%0d exp=0", seen); end
    total++; if (pif.busy !== 1'b1 || pif.remaining_display !== 4'd2) begin bad++; $display("FAIL hw_hold got=%b/%0d exp=1/2", pif.busy, pif.remaining_display); end
    pif.hopper_ready = 1'b1;
    serve(200, to);
    total++; if (to != 0 || got_ej.size() != 1) begin bad++; $display("FAIL hw_release got=%0d/%0d exp=0/1", to, got_ej.size()); end
    else begin
      total++; if (got_ej[0] != 2) begin bad++; $display("FAIL hw_coin got=%0d exp=2", got_ej[0]); end
    end
  endtask

  task automatic test_mid_reset();
    int to, e, g, found;
    clear_queues();
    send_req(3);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (pif.eject_2) begin found = 1; break; end
    end
    total++; if (found != 1) begin bad++; $display("FAIL mr_first_eject got=%0d exp=1", found); end
    reset = 1'b0;
    #1;
    total++; if (pif.eject_2 !== 1'b0 || pif.eject_1 !== 1'b0) begin bad++; $display("FAIL mr_eject got=%b%b exp=00", pif.eject_2, pif.eject_1); end
    total++; if (pif.busy !== 1'b0 || pif.payout_done !== 1'b0) begin bad++; $display("FAIL mr_status got=%b%b exp=00", pif.busy, pif.payout_done); end
    total++; if (pif.remaining_display !== 4'd0) begin bad++; $display("FAIL mr_rem got=%0d exp=0", pif.remaining_display); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_expected(1, 1'b0);
    send_req(1);
    serve(200, to);
    total++; if (to != 0) begin bad++; $display("FAIL mr_timeout got=%0d exp=0", to); end
    while (exp_ej.size() > 0) begin
      e = exp_ej.pop_front(); g = (got_ej.size() > 0) ? got_ej.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL mr_eject_after got=%0d exp=%0d", g, e); end
    end
    while (exp_rem.size() > 0) begin
      e = exp_rem.pop_front(); g = (got_rem.size() > 0) ? got_rem.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL mr_rem_after got=%0d exp=%0d", g, e); end
    end
    total++; if (got_ej.size() != 0) begin bad++; $display("FAIL mr_extra_eject got=%0d exp=0", got_ej.size()); end
  endtask

`ifdef PAYOUT_TIMEOUT_EN
  task automatic test_watchdog();
    int found, n;
    clear_queues();
    send_req(2);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (pif.eject_2) begin found = 1; break; end
    end
    total++; if (found != 1) begin bad++; $display("FAIL wd_eject got=%0d exp=1", found); end
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      n++;
      if (pif.fault) break;
    end
    total++; if (n != 16 || pif.fault !== 1'b1) begin bad++; $display("FAIL wd_delay got=%0d/%b exp=16/1", n, pif.fault); end
    total++; if (pif.remaining_display !== 4'd2) begin bad++; $display("FAIL wd_rem got=%0d exp=2", pif.remaining_display); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (pif.fault !== 1'b1) begin bad++; $display("FAIL wd_hold got=%b exp=1", pif.fault); end
    pif.fault_clr = 1'b1;
    @(posedge clk); #1;
    pif.fault_clr = 1'b0;
    total++; if (pif.busy !== 1'b0 || pif.fault !== 1'b0) begin bad++; $display("FAIL wd_clr got=%b%b exp=00", pif.busy, pif.fault); end
    total++; if (pif.remaining_display !== 4'd0) begin bad++; $display("FAIL wd_clr_rem got=%0d exp=0", pif.remaining_display); end
  endtask
`else
  task automatic test_watchdog();
    int to, fault_seen;
    clear_queues();
    send_req(1);
    fault_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (pif.fault) fault_seen++;
      pif.fault_clr = 1'b1;
    end
    pif.fault_clr = 1'b0;
    total++; if (fault_seen != 0) begin bad++; $display("FAIL nowd_fault got=%0d exp=0", fault_seen); end
    total++; if (pif.busy !== 1'b1 || pif.remaining_display !== 4'd1) begin bad++; $display("FAIL nowd_wait got=%b/%0d exp=1/1", pif.busy, pif.remaining_display); end
    pif.coin_sensed = 1'b1;
    serve(50, to);
    total++; if (to != 0 || done_cnt != 1) begin bad++; $display("FAIL nowd_finish got=%0d/%0d exp=0/1", to, done_cnt); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    clear_queues();
    test_reset();
    test_amount5();
    test_zero();
    test_no_2coin();
    test_ignore_req();
    test_hopper_wait();
    test_mid_reset();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
